// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
// A single shared hexaDigit decoder is fed from a frame-consistent shadow copy of the value.

module hexaDigit (
  input  logic [3:0] Hex,
  input  logic       DP,
  output logic [7:0] SSeg
);
  logic [6:0] w_pat;

  // Active-high gfedcba pattern; inverted below for the common-anode pins.
  always_comb begin
    w_pat = 7'h00;
    case (Hex)
      4'h0: w_pat = 7'h3F;
      4'h1: w_pat = 7'h06;
      4'h2: w_pat = 7'h5B;
      4'h3: w_pat = 7'h4F;
      4'h4: w_pat = 7'h66;
      4'h5: w_pat = 7'h6D;
      4'h6: w_pat = 7'h7D;
      4'h7: w_pat = 7'h07;
      4'h8: w_pat = 7'h7F;
      4'h9: w_pat = 7'h6F;
      4'hA: w_pat = 7'h77;
      4'hB: w_pat = 7'h7C;
      4'hC: w_pat = 7'h39;
      4'hD: w_pat = 7'h5E;
      4'hE: w_pat = 7'h79;
      4'hF: w_pat = 7'h71;
      default: w_pat = 7'h00;
    endcase
  end

  assign SSeg = ~{DP, w_pat};
endmodule

module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  localparam int VAL_W  = 4 * NUM_DIGITS,
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int TICK_W = $clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [VAL_W-1:0]      value,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  lz_suppress,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_start,
  output logic                  pending
);
  logic [TICK_W-1:0]     r_tick;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_frame_start;
  logic                  r_pending;
  logic [VAL_W-1:0]      r_stg_val;
  logic [NUM_DIGITS-1:0] r_stg_dp;
  logic                  r_stg_lz;
  logic [VAL_W-1:0]      r_shd_val;
  logic [NUM_DIGITS-1:0] r_shd_dp;
  logic                  r_shd_lz;
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_seg;

  logic                  w_tick_wrap;
  logic                  w_boundary;
  logic [3:0]            w_hex;
  logic                  w_dp;
  logic [7:0]            w_sseg;
  logic [NUM_DIGITS-1:0] w_supp;
  logic [NUM_DIGITS-1:0] w_an_next;

  assign w_tick_wrap = (r_tick == TICK_W'(REFRESH_DIV - 1));
  assign w_boundary  = w_tick_wrap && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_hex       = r_shd_val[{r_idx, 2'b00} +: 4];
  assign w_dp        = r_shd_dp[r_idx];

  hexaDigit u_dec (
    .Hex  (w_hex),
    .DP   (w_dp),
    .SSeg (w_sseg)
  );

  // A digit goes dark only while every nibble from it upward is zero and its own dp is off.
  always_comb begin
    logic w_zero_run;
    w_zero_run = 1'b1;
    w_supp     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_shd_val[4*k +: 4] == 4'h0);
      w_supp[k]  = r_shd_lz & w_zero_run & ~r_shd_dp[k] & (k != 0);
    end
  end

  always_comb begin
    w_an_next = '1;
    if ((r_tick >= TICK_W'(BLANK_CYCLES)) && !w_supp[r_idx])
      w_an_next[r_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick        <= '0;
      r_idx         <= '0;
      r_frame_start <= 1'b0;
      r_pending     <= 1'b0;
      r_stg_val     <= '0;
      r_stg_dp      <= '0;
      r_stg_lz      <= 1'b0;
      r_shd_val     <= '0;
      r_shd_dp      <= '0;
      r_shd_lz      <= 1'b0;
      r_an          <= '1;
      r_seg         <= 8'h00;
    end else begin
      r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
      if (w_tick_wrap)
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_frame_start <= w_boundary;
      // Shadow takes the pre-edge staging, so a load on the boundary waits one frame.
      if (w_boundary && r_pending) begin
        r_shd_val <= r_stg_val;
        r_shd_dp  <= r_stg_dp;
        r_shd_lz  <= r_stg_lz;
      end
      if (load) begin
        r_stg_val <= value;
        r_stg_dp  <= dp_in;
        r_stg_lz  <= lz_suppress;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
      r_an  <= w_an_next;
      r_seg <= w_sseg;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign digit_idx   = r_idx;
  assign frame_start = r_frame_start;
  assign pending     = r_pending;
endmodule
